// File: rtl/rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rd_pkg                                                     |
// | Purpose : Shared constants, mode encoding and rate helper for the    |
// |           multi-channel rate divider.                                |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rd_pkg;

  localparam int RD_N_CH_DEF  = 4;
  localparam int RD_WIDTH_DEF = 20;

  typedef enum logic {
    RD_PERIODIC = 1'b0,
    RD_ONESHOT  = 1'b1
  } rd_mode_e;

  // Reload value for a period of 'rate' cycles. Callers only use it with
  // rate != 0, so the subtraction never wraps. Rates up to 32 bits wide.
  function automatic logic [31:0] rd_rate_m1(input logic [31:0] rate);
    return rate - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rd_channel                                                 |
// | Purpose : One down-counting rate channel with periodic / one-shot    |
// |           mode. Priority: load > stop > sync > count.                |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rd_channel
  import rd_pkg::*;
#(
  parameter int WIDTH = RD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_rate,
  input  logic             i_oneshot,
  input  logic             i_stop,
  input  logic             i_sync,
  input  logic             i_stb,
  output logic             o_tick,
  output logic             o_busy
);

  logic [WIDTH-1:0] r_rate;
  logic [WIDTH-1:0] r_cnt;
  logic             r_run;
  rd_mode_e         r_mode;

  logic [WIDTH-1:0] w_rate_m1;
  logic [WIDTH-1:0] w_load_m1;
  logic             w_cnt_zero;

  // Reload values: stored rate for periodic reload/sync, incoming rate for writes
  assign w_rate_m1  = WIDTH'(rd_rate_m1(32'(r_rate)));
  assign w_load_m1  = WIDTH'(rd_rate_m1(32'(i_rate)));
  assign w_cnt_zero = (r_cnt == '0);

  // Channel state update, highest-priority source first
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_rate <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_mode <= RD_PERIODIC;
    end else if (i_load) begin
      r_rate <= i_rate;
      r_mode <= rd_mode_e'(i_oneshot);
      if (i_rate != '0) begin
        r_cnt <= w_load_m1;
        r_run <= 1'b1;
      end else begin
        r_cnt <= '0;
        r_run <= 1'b0;
      end
    end else if (i_stop) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_sync && r_run) begin
      r_cnt <= w_rate_m1;
    end else if (r_run && i_stb) begin
      if (!w_cnt_zero) begin
        r_cnt <= r_cnt - WIDTH'(1);
      end else if (r_mode == RD_ONESHOT) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= w_rate_m1;
      end
    end
  end

  // Tick is a decode of registered state, qualified by the shared strobe
  assign o_tick = r_run && w_cnt_zero && i_stb;
  assign o_busy = r_run;

endmodule
`default_nettype wire

// File: rtl/rd_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rd_multi                                                   |
// | Purpose : N_CH independent rate dividers with a register-write       |
// |           config port, per-channel stop and a global re-phase sync.  |
// | Options : RD_PRESCALE_EN adds a shared prescaler (port 'prescale')   |
// |           that slows every channel by a factor of prescale+1.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rd_multi
  import rd_pkg::*;
#(
  parameter int N_CH  = RD_N_CH_DEF,
  parameter int WIDTH = RD_WIDTH_DEF,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             clear,
`ifdef RD_PRESCALE_EN
  input  logic [WIDTH-1:0] prescale,
`endif
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_rate,
  input  logic             cfg_oneshot,
  input  logic [N_CH-1:0]  stop,
  input  logic             sync,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  logic w_pre_stb;

`ifdef RD_PRESCALE_EN
  logic [WIDTH-1:0] r_pre;

  // Shared prescaler: strobe when it reaches zero, reload on strobe or sync
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_pre <= '0;
    end else if (sync || w_pre_stb) begin
      r_pre <= prescale;
    end else begin
      r_pre <= r_pre - WIDTH'(1);
    end
  end

  assign w_pre_stb = (r_pre == '0);
`else
  assign w_pre_stb = 1'b1;
`endif

  // One channel per index; writes to indices >= N_CH match no channel
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic w_load;

    assign w_load = cfg_we && (cfg_ch == CH_W'(gi));

    rd_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk       (clk),
      .clear     (clear),
      .i_load    (w_load),
      .i_rate    (cfg_rate),
      .i_oneshot (cfg_oneshot),
      .i_stop    (stop[gi]),
      .i_sync    (sync),
      .i_stb     (w_pre_stb),
      .o_tick    (tick[gi]),
      .o_busy    (busy[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_rd_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rd_multi                                                |
// | Purpose : Directed, self-checking bench for rd_multi. Expected tick  |
// |           events are queued by cycle number when stimulus is driven  |
// |           and compared against the tick vector every cycle.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_rd_multi;

  localparam int N = 4;
`ifdef RD_PRESCALE_EN
  localparam int W = 8;
`else
  localparam int W = 20;
`endif
  localparam int CW = 2;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  logic           clk = 1'b0;
  logic           clear = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [W-1:0]   cfg_rate = '0;
  logic           cfg_oneshot = 1'b0;
  logic [N-1:0]   stop = '0;
  logic           sync = 1'b0;
  logic [N-1:0]   tick;
  logic [N-1:0]   busy;
`ifdef RD_PRESCALE_EN
  logic [W-1:0]   prescale = '0;
`endif

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  ev_t q[$];

  rd_multi #(
    .N_CH  (N),
    .WIDTH (W),
    .CH_W  (CW)
  ) dut (
    .clk         (clk),
    .clear       (clear),
`ifdef RD_PRESCALE_EN
    .prescale    (prescale),
`endif
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_rate    (cfg_rate),
    .cfg_oneshot (cfg_oneshot),
    .stop        (stop),
    .sync        (sync),
    .tick        (tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges seen so far
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Insert an expected tick keeping the queue ordered by cycle
  task automatic push_tick(input int ch, input int at);
    ev_t e;
    int  idx;
    e.ch  = ch;
    e.cyc = at;
    idx   = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > at) begin
        idx = i;
        break;
      end
    end
    q.insert(idx, e);
  endtask

  task automatic push_periodic(input int ch, input int first, input int period, input int count);
    for (int i = 0; i < count; i++) push_tick(ch, first + i * period);
  endtask

  // Advance one edge, sample at the falling edge and score the tick vector
  task automatic cycle();
    logic [N-1:0] exp;
    @(posedge clk);
    @(negedge clk);
    exp = '0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      if (q[0].cyc == cyc) exp[q[0].ch] = 1'b1;
      void'(q.pop_front());
    end
    chk("tick", 32'(tick), 32'(exp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Config write captured at the next edge; first tick lands 'rate' cycles on
  task automatic wr(input int ch, input int rate, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = CW'(ch);
    cfg_rate    = W'(rate);
    cfg_oneshot = os;
    cycle();
    cfg_we      = 1'b0;
    cfg_oneshot = 1'b0;
  endtask

  initial begin
    int c;

    // Reset state
    #3;
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    run(2);

    // Reset mid-count: clear asserted while ch0 tick is high
    c = cyc;
    push_tick(0, c + 5);
    wr(0, 5, 1'b0);
    chk("rst_busy_pre", 32'(busy), 32'h1);
    run(4);
    #2 clear = 1'b0;
    #1;
    chk("rst_async_tick", 32'(tick), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    q.delete();
    @(negedge clk);
    clear = 1'b1;
    run(12);
    chk("rst_after_busy", 32'(busy), 32'd0);

    // Periodic: ch1 rate 3 for five periods
    c = cyc;
    push_periodic(1, c + 3, 3, 5);
    wr(1, 3, 1'b0);
    run(14);
    chk("per_busy", 32'(busy), 32'h2);

    // Stop ch1: busy falls next cycle, no further ticks
    stop = 4'b0010;
    cycle();
    stop = '0;
    chk("stop_busy", 32'(busy), 32'd0);
    run(6);

    // Rate 1 on ch2: tick every cycle, then disable with rate 0
    c = cyc;
    push_periodic(2, c + 1, 1, 8);
    wr(2, 1, 1'b0);
    run(7);
    chk("rate1_busy", 32'(busy), 32'h4);
    wr(2, 0, 1'b0);
    chk("rate0_busy", 32'(busy), 32'd0);
    run(3);

    // One-shot ch0 rate 4: single tick, then idle
    c = cyc;
    push_tick(0, c + 4);
    wr(0, 4, 1'b1);
    run(3);
    chk("os_busy_at_tick", 32'(busy), 32'h1);
    cycle();
    chk("os_busy_after", 32'(busy), 32'd0);
    run(20);

    // Rate 0 write to ch3: silent
    wr(3, 0, 1'b0);
    chk("zero_busy", 32'(busy), 32'd0);
    run(3);

    // Write and stop to ch1 in the same cycle: write wins
    c = cyc;
    push_tick(1, c + 3);
    wr(1, 3, 1'b0);
    run(2);
    c = cyc;
    push_periodic(1, c + 4, 4, 2);
    stop = 4'b0010;
    wr(1, 4, 1'b0);
    stop = '0;
    chk("wr_stop_busy", 32'(busy), 32'h2);
    run(7);
    stop = 4'b0010;
    cycle();
    stop = '0;
    chk("wr_stop_end_busy", 32'(busy), 32'd0);

    // Sync: ch0 and ch1 rate 6 started two cycles apart, then re-phased
    c = cyc;
    wr(0, 6, 1'b0);
    cycle();
    wr(1, 6, 1'b0);
    push_periodic(0, c + 9, 6, 2);
    push_periodic(1, c + 9, 6, 2);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    run(11);
    chk("sync_busy", 32'(busy), 32'h3);
    stop = 4'b0011;
    cycle();
    stop = '0;
    chk("sync_stop_busy", 32'(busy), 32'd0);
    run(3);

`ifdef RD_PRESCALE_EN
    // Prescale 2, ch0 rate 2: period 6, aligned by sync on the write edge
    prescale = W'(2);
    c = cyc;
    push_periodic(0, c + 6, 6, 3);
    sync = 1'b1;
    wr(0, 2, 1'b0);
    sync = 1'b0;
    run(16);
    chk("pre_busy", 32'(busy), 32'h1);
    stop = 4'b0001;
    cycle();
    stop = '0;
    prescale = '0;
    sync = 1'b1;
    cycle();
    sync = 1'b0;

    // Maximum rate with prescale 0: period 255
    c = cyc;
    push_periodic(0, c + 255, 255, 2);
    wr(0, 255, 1'b0);
    run(510);
    chk("max_busy", 32'(busy), 32'h1);
    stop = 4'b0001;
    cycle();
    stop = '0;
    run(3);
`endif

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rd_multi.md
Name: rd_multi

Overview:
- Parametrised, multi-channel successor to the single-rate divider.
- N independent down-counters, each emitting a one-cycle tick every RATE clocks.
- Per-channel periodic or one-shot mode; a global sync re-phases all running channels.
- Sits between the clock domain root and the timing consumers (baud, display refresh, animation steps), configured by a simple register-write port.

Parameters:
- N_CH, 4, number of channels (1..16).
- WIDTH, 20, counter/rate width in bits.
- CH_W, 2, channel index width, equal to clog2(N_CH) with a minimum of 1.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- cfg_we  in  1  write strobe for channel configuration.
- cfg_ch  in  CH_W  target channel of write.
- cfg_rate  in  WIDTH  period in clk cycles; 0 = stop channel.
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic.
- stop  in  N_CH  per-channel synchronous stop request.
- sync  in  1  re-phase all running channels.
- tick  out  N_CH  one-cycle pulse per period, per channel.
- busy  out  N_CH  channel running.

Behaviour:
- Per-channel state: rate_q[WIDTH], cnt[WIDTH], run, oneshot.
- Reset (clear low, asynchronous): all rate_q=0, cnt=0, run=0, oneshot=0, so tick=0 and busy=0. Release is synchronous to the next clk edge.
- tick[i] = run[i] && cnt[i]==0. It is a combinational decode of registered state.
- busy[i] = run[i].
- Write, when cfg_we is sampled at edge k with cfg_ch=i and R=cfg_rate:
  - rate_q<=R, oneshot<=cfg_oneshot.
  - If R!=0: cnt<=R-1, run<=1. The first tick occurs in the cycle after edge k+R-1, i.e. R cycles after the write edge.
  - If R==0: cnt<=0, run<=0, and the channel is silent.
- Running, with no write, stop or sync:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 and periodic: cnt<=rate_q-1. Period is exactly rate_q cycles; rate_q=1 gives tick high every cycle.
  - cnt==0 and one-shot: run<=0, cnt holds 0. Exactly one tick per write.
- Idle (run=0): cnt holds; no tick.
- stop[i] at an edge: run<=0, cnt<=0. A tick visible in that same cycle still counts as delivered.
- sync at an edge: every channel with run=1 gets cnt<=rate_q-1. Idle channels are unaffected. All synced channels of equal rate then tick in the same cycle.
- Priority per channel, highest first: write to that channel > stop > sync > normal count.
- Arithmetic: rate_q-1 is computed at WIDTH bits, with no wrap because rate_q!=0 whenever run=1. The maximum period is 2^WIDTH-1.
- cfg_ch >= N_CH: the write is ignored.

Optional Feature:
- Macro RD_PRESCALE_EN.
- Defined:
  - Adds input prescale[WIDTH] and a shared prescaler counter producing strobe pre_stb every prescale+1 clk cycles; prescale=0 gives a strobe every cycle.
  - Channel cnt decrement/reload and one-shot clear occur only on cycles with pre_stb.
  - tick[i] = run && cnt==0 && pre_stb, so the period is rate_q*(prescale+1) cycles.
  - Writes, stop and sync act immediately, independent of pre_stb.
  - sync also reloads the prescaler to prescale.
  - Reset value of the prescaler counter: 0.
- Undefined: no prescale port; pre_stb is constant 1; behaviour is as above.

Decomposition:
- Package rd_pkg:
  - default WIDTH and N_CH constants.
  - mode enum {RD_PERIODIC, RD_ONESHOT}.
  - function for rate minus one.
- Sub-module rd_channel:
  - one counter with run/oneshot state and priority logic.
  - inputs: load, rate, oneshot, stop, sync, stb.
  - outputs: tick, busy.
  - instantiated N_CH times by generate.
- Top rd_multi: write decode, prescaler and output concatenation.

Test Plan:
- Reset mid-count: ch0 rate=5 running; assert clear low asynchronously between edges -> tick=0 and busy=0 immediately; after release, no tick for at least 10 cycles.
- Periodic: write ch1 rate=3 -> tick[1] high 3 cycles after the write edge, then every 3 cycles, for 5 periods; rate=1 on ch2 -> tick[2] continuously high.
- One-shot: write ch0 rate=4, oneshot=1 -> exactly one tick 4 cycles later, then busy[0]=0 and no further ticks for 20 cycles.
- Zero/stop: write ch3 rate=0 -> busy=0 and no tick; ch1 running and stop[1] pulsed -> busy[1] falls the next cycle with no further tick; write to ch1 in the same cycle as stop[1] -> the write wins and the channel restarts.
- Sync: ch0 rate=6 and ch1 rate=6 started 2 cycles apart, then pulse sync -> both tick together 6 cycles after the sync edge; idle ch2 remains silent.
- Prescale (RD_PRESCALE_EN): prescale=2, ch0 rate=2 -> tick period of 6 cycles; max rate 2^WIDTH-1 with prescale=0 -> period matches exactly (shorten WIDTH to 8 in the bench: 255 cycles).
